// File: rtl/sha256_pad_sched.sv
// SHA-256 front-end: packs a 32-bit big-endian word stream into 512-bit blocks,
// appends the 0x80 marker, zero fill and 64-bit bit-length, and hands each block
// to the compression core over a start/done handshake using one block buffer.
// Optional build macro SHA_SCHED_TIMEOUT_EN enables a core_done watchdog (TIMEOUT_CYC)
// that raises a sticky err and abandons the message; without it err is tied 0.
module sha256_pad_sched #(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned CNT_W       = 61
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic [511:0] core_block,
    output logic         core_start,
    output logic         core_init,
    input  logic         core_done,
    output logic         msg_done,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {StFill, StPad, StIssue, StWait, StDone} state_e;

    state_e         state_q;
    logic [511:0]   blk_q;
    logic [3:0]     idx_q;
    logic [CNT_W-1:0] bytes_q;
    logic           first_q;     // next issued block starts a message
    logic           more_q;      // data words still to come after this block
    logic           final_q;     // block in flight carries the length
    logic           pad80_q;     // 0x80 marker already written
    logic           len_q;       // upper length word written, lower one next
    logic           in_ready_q;
    logic           start_q;
    logic           init_q;
    logic           msg_done_q;
    logic           busy_q;

    logic [2:0]     nb;
    logic [31:0]    fill_word;
    logic [31:0]    pad_word;
    logic [63:0]    bit_len;
    logic [8:0]     wr_lsb;
    logic           accept;

`ifdef SHA_SCHED_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    logic [TmoW-1:0] tmo_q;
    logic            err_q;
`endif

    // Byte count of the incoming word and the word with the 0x80 marker merged in
    always_comb begin
        nb        = (in_last && in_bytes != 2'd0) ? {1'b0, in_bytes} : 3'd4;
        fill_word = in_data;
        case (in_last ? in_bytes : 2'd0)
            2'd1:    fill_word = {in_data[31:24], 8'h80, 16'h0000};
            2'd2:    fill_word = {in_data[31:16], 8'h80, 8'h00};
            2'd3:    fill_word = {in_data[31:8], 8'h80};
            default: fill_word = in_data;
        endcase
        bit_len = 64'(bytes_q) << 3;
        // Word i lives at bits [511-32*i -: 32], i.e. starting at 32*(15-i)
        wr_lsb  = {~idx_q, 5'd0};
        if (!pad80_q) begin
            pad_word = 32'h8000_0000;
        end else if (len_q) begin
            pad_word = bit_len[31:0];
        end else if (idx_q == 4'd14) begin
            pad_word = bit_len[63:32];
        end else begin
            pad_word = 32'h0000_0000;
        end
        accept = in_valid && in_ready_q;
    end

    // Sequencer: fill, pad, issue, wait for core, finish message
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFill;
            blk_q      <= '0;
            idx_q      <= '0;
            bytes_q    <= '0;
            first_q    <= 1'b1;
            more_q     <= 1'b0;
            final_q    <= 1'b0;
            pad80_q    <= 1'b0;
            len_q      <= 1'b0;
            in_ready_q <= 1'b0;
            start_q    <= 1'b0;
            init_q     <= 1'b0;
            msg_done_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SHA_SCHED_TIMEOUT_EN
            tmo_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            start_q    <= 1'b0;
            init_q     <= 1'b0;
            msg_done_q <= 1'b0;
            unique case (state_q)
                StFill: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        blk_q[wr_lsb +: 32] <= fill_word;
                        idx_q   <= idx_q + 4'd1;
                        bytes_q <= bytes_q + CNT_W'(nb);
                        busy_q  <= 1'b1;
                        pad80_q <= (nb != 3'd4);
                        if (idx_q == 4'd15) begin
                            // Buffer full: issue now, padding follows in a later block
                            state_q    <= StIssue;
                            start_q    <= 1'b1;
                            init_q     <= first_q;
                            more_q     <= !in_last;
                            final_q    <= 1'b0;
                            in_ready_q <= 1'b0;
                        end else if (in_last) begin
                            state_q    <= StPad;
                            more_q     <= 1'b0;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                StPad: begin
                    blk_q[wr_lsb +: 32] <= pad_word;
                    idx_q   <= idx_q + 4'd1;
                    pad80_q <= 1'b1;
                    if (pad80_q && idx_q == 4'd14) begin
                        len_q <= 1'b1;
                    end
                    if (idx_q == 4'd15) begin
                        // Length fits only if the upper word went in at index 14
                        state_q <= StIssue;
                        start_q <= 1'b1;
                        init_q  <= first_q;
                        final_q <= len_q;
                        len_q   <= 1'b0;
                    end
                end
                StIssue: begin
                    first_q <= 1'b0;
                    state_q <= StWait;
`ifdef SHA_SCHED_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                end
                StWait: begin
                    if (core_done) begin
                        if (final_q) begin
                            state_q    <= StDone;
                            msg_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            blk_q <= '0;
                            idx_q <= '0;
                            if (more_q) begin
                                state_q    <= StFill;
                                in_ready_q <= 1'b1;
                            end else begin
                                state_q <= StPad;
                            end
                        end
`ifdef SHA_SCHED_TIMEOUT_EN
                    end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                        // Core stalled: drop the message and wait for a fresh one
                        err_q      <= 1'b1;
                        state_q    <= StFill;
                        in_ready_q <= 1'b1;
                        first_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        bytes_q    <= '0;
                        idx_q      <= '0;
                        blk_q      <= '0;
                        more_q     <= 1'b0;
                        final_q    <= 1'b0;
                        pad80_q    <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
`endif
                    end
                end
                StDone: begin
                    state_q    <= StFill;
                    in_ready_q <= 1'b1;
                    first_q    <= 1'b1;
                    bytes_q    <= '0;
                    idx_q      <= '0;
                    blk_q      <= '0;
                    more_q     <= 1'b0;
                    final_q    <= 1'b0;
                    pad80_q    <= 1'b0;
                end
                default: state_q <= StFill;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign core_block = blk_q;
    assign core_start = start_q;
    assign core_init  = init_q;
    assign msg_done   = msg_done_q;
    assign busy       = busy_q;
`ifdef SHA_SCHED_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: doc/sha256_pad_sched.md
Name: sha256_pad_sched

Overview:
Front-end sequencer for the SHA-256 compression core. Accepts a message as a 32-bit big-endian word stream and assembles 512-bit blocks, appending FIPS 180-4 padding and the 64-bit bit-length. Issues each block to the core with a start pulse and waits for the core to finish before reusing its single block buffer. Flags the first block of each message so the core re-initialises H0..H7.

Parameters:
TIMEOUT_CYC, 256, max cycles from core_start to core_done before error; used only with the optional feature.
CNT_W, 61, width of the byte counter; bit-length = {bytes, 3'b000}, zero-extended to 64 bits.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid&in_ready
in_data  in  32  message word, first byte in [31:24]
in_last  in  1  final word of message
in_bytes  in  2  valid bytes in last word; 0 means 4; ignored unless in_last
core_block  out  512  block, word i at [511-32*i -: 32]
core_start  out  1  one-cycle pulse, block ready
core_init  out  1  block is first of message; valid with core_start
core_done  in  1  one-cycle pulse, core finished current block
msg_done  out  1  one-cycle pulse, final block of message hashed
busy  out  1  message in progress
err  out  1  sticky timeout flag (optional feature; else tied 0)

Behaviour:
- Reset (async, rst_n=0): all outputs 0, block buffer 0, word index 0, byte count 0, first_flag=1, state FILL.
- States: FILL, PAD, ISSUE, WAIT, DONE.
- FILL: in_ready=1. Each accepted word goes to index idx, idx++, bytes += 4 (or in_bytes on last, 0→4); busy=1 from first accepted word.
  - idx reaches 16 without last → ISSUE, set more_data=1.
  - in_last with n<4: bytes [n..3] zeroed, byte n = 0x80 → PAD, pad_80_done=1.
  - in_last with n=4: word stored as is → PAD, pad_80_done=0.
- PAD: in_ready=0; writes one word per cycle at idx:
  - 0x80000000 if pad_80_done=0 (then set it);
  - else if idx<14: 0;
  - idx=14/15 with length not yet placed and 0x80 placed at idx<=14... precisely: if entering length zone (idx=14), word14 = len[63:32], word15 = len[31:0] (two cycles), then ISSUE, final=1.
  - if 0x80 word landed at index 14 or 15: zero-fill to 15, ISSUE with final=0; the next block is all zero with length at 14/15, final=1.
- ISSUE: core_start=1 for exactly one cycle, core_init=first_flag; clear first_flag → WAIT.
- WAIT: core_block held stable; in_ready=0. On core_done:
  - not final: clear buffer, idx=0, return to FILL (if data pending) or PAD (length-only block);
  - final: → DONE.
- DONE: msg_done=1 one cycle (one cycle after core_done); busy=0, first_flag=1, byte count=0, idx=0 → FILL.
- core_done outside WAIT is ignored.
- Latency: core_start is asserted 1 cycle after the 16th word is accepted, or 1 cycle after the last PAD write.
- Empty messages are not supported; minimum message length is 1 byte.
- rst_n mid-operation aborts the message and drops any pending core_start; core state is the core's own concern.

Optional Feature:
SHA_SCHED_TIMEOUT_EN:
- Defined: a counter runs in WAIT. If TIMEOUT_CYC cycles elapse without core_done, err is set sticky until reset, the message is abandoned, no msg_done is issued, and the block returns to FILL with first_flag=1.
- Undefined: no counter; err is tied 0 and WAIT lasts indefinitely.

Test Plan:
- "abc": one word 0x61626300, last, in_bytes=3 → one core_start with core_init=1; word0=0x61626380, words1-14=0, word15=0x00000018; core_done → msg_done the next cycle.
- 56-byte message (14 words, last n=4) → block 1 has word14=0x80000000, word15=0; block 2 words0-13=0, word14=0, word15=0x000001C0; core_init only on block 1.
- 64-byte message (16 words) → data block, then pad block with word0=0x80000000, word15=0x00000200; exactly 2 core_start pulses.
- Backpressure: drive in_valid continuously across a block boundary → in_ready=0 from ISSUE until core_done, no word lost or duplicated, core_block stable throughout WAIT.
- rst_n low during WAIT → all outputs 0 immediately; a following "abc" message hashes with core_init=1.
- With SHA_SCHED_TIMEOUT_EN, TIMEOUT_CYC=8, core_done withheld → err=1 after 8 WAIT cycles, no msg_done, in_ready=1 on the next cycle.
